// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : shared types and constants for the ALU-stage hazard control
// Rev 1.0
// ============================================================================
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Tracker dest field is sized for the widest supported register file;
  // narrower addresses are zero-extended so comparisons use every bit.
  localparam int DEST_W_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [DEST_W_MAX-1:0] dest;
    logic                  is_load;
  } trk_entry_t;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// fwd_select : youngest-match bypass priority encoder for one operand
// Rev 1.0
// ============================================================================
module fwd_select
  import alu_ctrl_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          use_src,
  input  logic [AW-1:0] src,
  input  logic [2:0]    ent_valid,
  input  logic [2:0]    ent_we,
  input  logic [2:0]    ent_load,
  input  logic [AW-1:0] dest0,
  input  logic [AW-1:0] dest1,
  input  logic [AW-1:0] dest2,
  output logic [1:0]    sel
);

  logic hit0;
  logic hit1;
  logic hit2;

  always_comb begin
    // A load sitting in the ALU stage has no result yet, so it cannot bypass.
    hit0 = ent_valid[0] & ent_we[0] & ~ent_load[0] & (dest0 == src);
    hit1 = ent_valid[1] & ent_we[1] & (dest1 == src);
    hit2 = ent_valid[2] & ent_we[2] & (dest2 == src);
    sel  = FWD_RF;
    if (use_src) begin
      if (hit0)      sel = FWD_ALU;
      else if (hit1) sel = FWD_MEM;
      else if (hit2) sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// alu_hazard_ctrl : ALU-stage sequencer - write tracker, bypass selects,
//                   load-use stall, overflow squash/flush and memory freeze
// Rev 1.0
// ============================================================================
module alu_hazard_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  input  logic              use_a,
  input  logic              use_b,
  input  logic [REG_AW-1:0] dest,
  input  logic              we_in,
  input  logic              is_load,
  input  logic              alu_ovf,
  input  logic              mem_busy,
  output logic              enable_alu,
  output logic              decode_hold,
  output logic              we_alu,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              squash_alu,
  output logic              flush
);

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  trk_entry_t       trk_q [3];
  trk_entry_t       trk_d [3];

  logic [DEST_W_MAX-1:0] src_a_x;
  logic [DEST_W_MAX-1:0] src_b_x;
  logic [DEST_W_MAX-1:0] dest_x;
  logic                  in_flush;
  logic                  ovf;
  logic                  hazard;
  logic                  issue;
  logic [2:0]            ent_valid;
  logic [2:0]            ent_we;
  logic [2:0]            ent_load;

  always_comb begin
    src_a_x                = '0;
    src_b_x                = '0;
    dest_x                 = '0;
    src_a_x[REG_AW-1:0]    = src_a;
    src_b_x[REG_AW-1:0]    = src_b;
    dest_x[REG_AW-1:0]     = dest;

    ent_valid = {trk_q[2].valid,   trk_q[1].valid,   trk_q[0].valid};
    ent_we    = {trk_q[2].we,      trk_q[1].we,      trk_q[0].we};
    ent_load  = {trk_q[2].is_load, trk_q[1].is_load, trk_q[0].is_load};

    in_flush = (state_q == ST_FLUSH);
    ovf      = alu_ovf & trk_q[0].valid & ~in_flush;
    hazard   = issue_valid & trk_q[0].valid & trk_q[0].we & trk_q[0].is_load &
               ((use_a & (trk_q[0].dest == src_a_x)) |
                (use_b & (trk_q[0].dest == src_b_x)));
    issue    = issue_valid & ~mem_busy & ~in_flush & ~hazard & ~ovf;

    enable_alu  = ~mem_busy;
    decode_hold = mem_busy | in_flush | ovf | hazard;
    we_alu      = we_in & issue;
    squash_alu  = ovf & ~mem_busy;
    flush       = in_flush;
  end

  // STALL marks the replay cycle: the single bubble is inserted in the cycle
  // the hazard is seen, so the held instruction issues while the load is in MEM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) trk_d[i] = trk_q[i];

    if (!mem_busy) begin
      trk_d[2] = trk_q[1];
      trk_d[1] = trk_q[0];
      if (ovf) trk_d[1].we = 1'b0;
      trk_d[0] = '0;
      if (issue) begin
        trk_d[0].valid   = 1'b1;
        trk_d[0].we      = we_in;
        trk_d[0].dest    = dest_x;
        trk_d[0].is_load = is_load;
      end

      case (state_q)
        ST_RUN, ST_STALL: begin
          if (ovf) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_LOAD;
          end else if (hazard) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      for (int i = 0; i < 3; i++) trk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 3; i++) trk_q[i] <= trk_d[i];
    end
  end

  fwd_select #(.AW(DEST_W_MAX)) u_fwd_a (
    .use_src   (use_a),
    .src       (src_a_x),
    .ent_valid (ent_valid),
    .ent_we    (ent_we),
    .ent_load  (ent_load),
    .dest0     (trk_q[0].dest),
    .dest1     (trk_q[1].dest),
    .dest2     (trk_q[2].dest),
    .sel       (fwd_a)
  );

  fwd_select #(.AW(DEST_W_MAX)) u_fwd_b (
    .use_src   (use_b),
    .src       (src_b_x),
    .ent_valid (ent_valid),
    .ent_we    (ent_we),
    .ent_load  (ent_load),
    .dest0     (trk_q[0].dest),
    .dest1     (trk_q[1].dest),
    .dest2     (trk_q[2].dest),
    .sel       (fwd_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_hazard_ctrl : directed bench for the ALU-stage hazard controller
// Rev 1.0
// ============================================================================
module tb_alu_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       issue_valid, use_a, use_b, we_in, is_load, alu_ovf, mem_busy;
  logic [2:0] src_a, src_b, dest;
  logic       enable_alu, decode_hold, we_alu, squash_alu, flush;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  alu_hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .src_a       (src_a),
    .src_b       (src_b),
    .use_a       (use_a),
    .use_b       (use_b),
    .dest        (dest),
    .we_in       (we_in),
    .is_load     (is_load),
    .alu_ovf     (alu_ovf),
    .mem_busy    (mem_busy),
    .enable_alu  (enable_alu),
    .decode_hold (decode_hold),
    .we_alu      (we_alu),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .squash_alu  (squash_alu),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sa, input logic ua,
                       input logic [2:0] sb, input logic ub, input logic [2:0] d,
                       input logic w, input logic ld);
    issue_valid = v;
    src_a       = sa;
    use_a       = ua;
    src_b       = sb;
    use_b       = ub;
    dest        = d;
    we_in       = w;
    is_load     = ld;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    alu_ovf  = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    idle();
    #2;
    chk("rst_enable", enable_alu, 2'd1);
    chk("rst_hold",   decode_hold, 2'd0);
    chk("rst_we",     we_alu, 2'd0);
    chk("rst_fwd_a",  fwd_a, 2'd0);
    chk("rst_fwd_b",  fwd_b, 2'd0);
    chk("rst_squash", squash_alu, 2'd0);
    chk("rst_flush",  flush, 2'd0);
    tick();
    reset = 1'b1;

    // writer r1, then reader of r1 as it ages through the tracker
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    #1 chk("wr_we", we_alu, 2'd1);
    chk("wr_fwd_a", fwd_a, 2'd0);
    tick();
    drive(1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1 chk("age0_fwd_a", fwd_a, 2'd1);
    chk("age0_hold", decode_hold, 2'd0);
    tick();
    #1 chk("age1_fwd_a", fwd_a, 2'd2);
    tick();
    #1 chk("age2_fwd_a", fwd_a, 2'd3);
    tick();
    #1 chk("age3_fwd_a", fwd_a, 2'd0);
    tick();

    // two writers of r2 back to back: youngest must win
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd6, 1'b0, 1'b0);
    #1 chk("young_e0_fwd_b", fwd_b, 2'd1);
    chk("young_e0_hold", decode_hold, 2'd0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
    #1 chk("young_e1_fwd_b", fwd_b, 2'd2);
    tick();
    drain();

    // load-use: one held cycle, then issue from MEM
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    #1 chk("ld_we", we_alu, 2'd1);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0);
    #1 chk("lu_hold", decode_hold, 2'd1);
    chk("lu_we", we_alu, 2'd0);
    tick();
    #1 chk("lu_rel_hold", decode_hold, 2'd0);
    chk("lu_rel_fwd_b", fwd_b, 2'd2);
    chk("lu_rel_we", we_alu, 2'd1);
    tick();
    drain();

    // freeze for 3 cycles in the middle of the stall
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0);
    #1 chk("fz_pre_hold", decode_hold, 2'd1);
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fz_enable", enable_alu, 2'd0);
      chk("fz_hold", decode_hold, 2'd1);
      chk("fz_we", we_alu, 2'd0);
      chk("fz_fwd_b", fwd_b, 2'd2);
      tick();
    end
    mem_busy = 1'b0;
    #1 chk("fz_rel_enable", enable_alu, 2'd1);
    chk("fz_rel_hold", decode_hold, 2'd0);
    chk("fz_rel_fwd_b", fwd_b, 2'd2);
    chk("fz_rel_we", we_alu, 2'd1);
    tick();
    drive(1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1 chk("fz_add_in_alu", fwd_a, 2'd1);
    tick();
    drain();

    // overflow on a writer of r2: squash, then two flush cycles
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
    alu_ovf = 1'b1;
    #1 chk("ovf_squash", squash_alu, 2'd1);
    chk("ovf_hold", decode_hold, 2'd1);
    chk("ovf_we", we_alu, 2'd0);
    chk("ovf_flush", flush, 2'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1 chk("fl_flush", flush, 2'd1);
      chk("fl_squash", squash_alu, 2'd0);
      chk("fl_hold", decode_hold, 2'd1);
      chk("fl_fwd_a", fwd_a, 2'd0);
      chk("fl_we", we_alu, 2'd0);
      tick();
    end
    alu_ovf = 1'b0;
    #1 chk("fl_end_flush", flush, 2'd0);
    chk("fl_end_hold", decode_hold, 2'd0);
    chk("fl_end_fwd_a", fwd_a, 2'd0);
    chk("fl_end_we", we_alu, 2'd1);
    tick();
    drain();

    // overflow beats load-use; freeze defers both
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0);
    alu_ovf  = 1'b1;
    mem_busy = 1'b1;
    #1 chk("pr_fz_squash", squash_alu, 2'd0);
    chk("pr_fz_enable", enable_alu, 2'd0);
    chk("pr_fz_hold", decode_hold, 2'd1);
    tick();
    mem_busy = 1'b0;
    #1 chk("pr_squash", squash_alu, 2'd1);
    chk("pr_we", we_alu, 2'd0);
    tick();
    alu_ovf = 1'b0;
    #1 chk("pr_flush", flush, 2'd1);
    tick();

    // reset in the middle of FLUSH
    idle();
    use_a = 1'b1;
    src_a = 3'd3;
    reset = 1'b0;
    #1 chk("mr_flush", flush, 2'd0);
    chk("mr_hold", decode_hold, 2'd0);
    chk("mr_squash", squash_alu, 2'd0);
    chk("mr_enable", enable_alu, 2'd1);
    chk("mr_fwd_a", fwd_a, 2'd0);
    tick();
    reset = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    #1 chk("mr_issue_we", we_alu, 2'd1);
    chk("mr_issue_hold", decode_hold, 2'd0);
    tick();
    drive(1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1 chk("mr_issue_fwd_a", fwd_a, 2'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
